// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the fetch pipeline.
//   NOP_ENC      - bubble encoding (addi x0,x0,0)
//   RESET_PC_DEF - default first fetch address after reset
//   fetch_state_t- IF-stage fetch FSM states
package riscv_pkg;
  localparam logic [31:0] NOP_ENC      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // request outstanding on imem, waiting for gnt
    S_WAIT = 2'd1,  // granted, waiting for rvalid
    S_HOLD = 2'd2   // data returned while decode stalled; held in buf_q
  } fetch_state_t;
endpackage

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with single outstanding imem fetch.
// Owns the PC, talks req/gnt/rvalid to imem and loads the IF/ID register.
// Ports:
//   clk, rstn                         clock / async active-low reset
//   imem_req, imem_addr               fetch request and word address
//   imem_gnt, imem_rvalid, imem_rdata imem handshake and read data
//   id_stall                          decode cannot accept, IF/ID holds
//   redirect_valid, redirect_pc       taken branch/jump: flush and refetch
//   if_instr, if_pc, if_valid         IF/ID pipeline register
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid
);

  fetch_state_t r_state, w_state_d;
  logic [31:0]  r_pc, w_pc_d;
  logic [31:0]  r_req_pc, w_req_pc_d;
  logic [31:0]  r_buf, w_buf_d;
  logic         r_kill, w_kill_d;
  logic         w_load;
  logic [31:0]  w_load_instr;

  // Gated with rstn so no request leaks out while reset is held.
  assign imem_req  = rstn && (r_state == S_REQ);
  assign imem_addr = r_pc;

  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_req_pc_d   = r_req_pc;
    w_buf_d      = r_buf;
    w_kill_d     = r_kill;
    w_load       = 1'b0;
    w_load_instr = r_buf;
    case (r_state)
      S_REQ: begin
        if (imem_gnt) begin
          w_req_pc_d = r_pc;
          w_pc_d     = r_pc + 32'd4;
          w_state_d  = S_WAIT;
          // Fetch already accepted on the old path; drop its data later.
          if (redirect_valid) w_kill_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (r_kill || redirect_valid) begin
            w_kill_d  = 1'b0;
            w_state_d = S_REQ;
          end else if (!id_stall) begin
            w_load       = 1'b1;
            w_load_instr = imem_rdata;
            w_state_d    = S_REQ;
          end else begin
            w_buf_d   = imem_rdata;
            w_state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          w_kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_state_d = S_REQ;
        end else if (!id_stall) begin
          w_load       = 1'b1;
          w_load_instr = r_buf;
          w_state_d    = S_REQ;
        end
      end
      default: w_state_d = S_REQ;
    endcase
    // Redirect target overrides the sequential increment.
    if (redirect_valid) w_pc_d = redirect_pc & ~32'd3;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_buf    <= '0;
      r_kill   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_pc     <= w_pc_d;
      r_req_pc <= w_req_pc_d;
      r_buf    <= w_buf_d;
      r_kill   <= w_kill_d;
    end
  end

  // IF/ID register: redirect bubbles, load fills, otherwise bubble unless stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if_instr <= NOP_INSTR;
      if_pc    <= '0;
      if_valid <= 1'b0;
    end else if (redirect_valid) begin
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
    end else if (w_load) begin
      if_instr <= w_load_instr;
      if_pc    <= r_req_pc;
      if_valid <= 1'b1;
    end else if (!id_stall) begin
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
    end
  end

endmodule
